// File: rtl/id1000500a_conv_pkg.sv
// Shared constants for the id1000500a convolution peripheral: AIP register map,
// IP identifier, STATUS bit positions, FSM state codes and the accumulate helper.
// Build option: define CONV_SAT_EN to make the accumulator saturate to the signed
// 32-bit range instead of wrapping modulo 2^32.
package id1000500a_conv_pkg;

   localparam int DATAWIDTH  = 32;
   localparam int MEMX_DEPTH = 32;
   localparam int MEMY_DEPTH = 32;
   localparam int MEMZ_DEPTH = 64;

   localparam logic [DATAWIDTH-1:0] IP_ID = 32'h1000_500A;

   // conf_dbus address map
   localparam logic [4:0] ADDR_MDATAINX = 5'd0;
   localparam logic [4:0] ADDR_ADATAINX = 5'd1;
   localparam logic [4:0] ADDR_MDATAINY = 5'd2;
   localparam logic [4:0] ADDR_ADATAINY = 5'd3;
   localparam logic [4:0] ADDR_MDATAOUT = 5'd4;
   localparam logic [4:0] ADDR_ADATAOUT = 5'd5;
   localparam logic [4:0] ADDR_DCONFIG  = 5'd6;
   localparam logic [4:0] ADDR_ACONFIG  = 5'd7;
   localparam logic [4:0] ADDR_STATUS   = 5'd30;
   localparam logic [4:0] ADDR_IP_ID    = 5'd31;

   // STATUS register layout
   localparam int STAT_DONE    = 0;
   localparam int STAT_BUSY    = 8;
   localparam int STAT_MASK_LO = 16;

   // Core FSM state codes
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // Accumulate one product into the running sum.
   function automatic logic [DATAWIDTH-1:0] acc_add(input logic [DATAWIDTH-1:0] a,
                                                    input logic [DATAWIDTH-1:0] b);
`ifdef CONV_SAT_EN
      logic [DATAWIDTH:0] s;
      s = {a[DATAWIDTH-1], a} + {b[DATAWIDTH-1], b};
      if (s[DATAWIDTH] != s[DATAWIDTH-1])
         return s[DATAWIDTH] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return s[DATAWIDTH-1:0];
`else
      return a + b;
`endif
   endfunction

endpackage

// File: rtl/id1000500a_conv_core.sv
// Convolution engine: walks output index n and tap index k, one multiply-accumulate
// per cycle, and writes each Z word the cycle its sum completes. The last word is
// written from the FIN state. Sizes must stay stable while the engine is busy.
// Build option: CONV_SAT_EN (saturating accumulate, via acc_add in the package).
module id1000500a_conv_core
   import id1000500a_conv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_a,
   input  logic                 en_s,
   input  logic                 go,
   input  logic [4:0]           size_x,
   input  logic [4:0]           size_y,
   input  logic [DATAWIDTH-1:0] x_data,
   input  logic [DATAWIDTH-1:0] y_data,
   output logic [4:0]           x_addr,
   output logic [4:0]           y_addr,
   output logic                 z_we,
   output logic [5:0]           z_addr,
   output logic [DATAWIDTH-1:0] z_data,
   output logic                 done_set,
   output logic [1:0]           dbg_state
);

   logic [1:0]           state;
   logic [5:0]           n;
   logic [4:0]           k;
   logic [DATAWIDTH-1:0] acc;

   logic                 empty;
   logic [5:0]           n_last;
   logic [5:0]           n_nxt;
   logic [4:0]           k_max;
   logic [4:0]           k_first;
   logic [DATAWIDTH-1:0] prod;
   logic [DATAWIDTH-1:0] acc_sum;

   // Index bounds for the current output word and the first tap of the next one.
   always_comb begin
      empty   = (size_x == 5'd0) || (size_y == 5'd0);
      n_last  = {1'b0, size_x} + {1'b0, size_y} - 6'd2;
      n_nxt   = n + 6'd1;
      k_max   = (n < {1'b0, size_x}) ? n[4:0] : size_x - 5'd1;
      k_first = (n_nxt >= {1'b0, size_y}) ? 5'(n_nxt - {1'b0, size_y} + 6'd1) : 5'd0;
      x_addr  = k;
      y_addr  = 5'(n - {1'b0, k});
      prod    = x_data * y_data;
      acc_sum = acc_add(acc, prod);
   end

   // Z write port: intermediate words in CALC, the final word in FIN.
   always_comb begin
      z_we     = 1'b0;
      z_addr   = n;
      z_data   = acc_sum;
      done_set = (state == ST_FIN);
      if (state == ST_CALC)
         z_we = !empty && (k == k_max) && (n != n_last);
      else if (state == ST_FIN) begin
         z_we   = !empty;
         z_data = acc;
      end
   end

   // FSM and MAC counters: IDLE -> CALC -> FIN -> IDLE.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state <= ST_IDLE;
         n     <= '0;
         k     <= '0;
         acc   <= '0;
      end else if (en_s) begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  state <= ST_CALC;
                  n     <= '0;
                  k     <= '0;
                  acc   <= '0;
               end
            end
            ST_CALC: begin
               if (empty) begin
                  state <= ST_FIN;
               end else if (k == k_max) begin
                  if (n == n_last) begin
                     acc   <= acc_sum;
                     state <= ST_FIN;
                  end else begin
                     n   <= n_nxt;
                     k   <= k_first;
                     acc <= '0;
                  end
               end else begin
                  k   <= k + 5'd1;
                  acc <= acc_sum;
               end
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: rtl/id1000500a_conv.sv
// AIP-bus slave wrapper: register/memory decode, auto-incrementing memory pointers,
// X/Y/Z memories, DCONFIG sizes and STATUS (DONE flag, interrupt mask).
// Build option: CONV_SAT_EN selects a saturating accumulator inside the core.
// The configuration memory has a single entry, so its pointer is always 0.
module id1000500a_conv
   import id1000500a_conv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_a,
   input  logic                 en_s,
   input  logic [DATAWIDTH-1:0] data_in,
   output logic [DATAWIDTH-1:0] data_out,
   input  logic                 write,
   input  logic                 read,
   input  logic                 start,
   input  logic [4:0]           conf_dbus,
   output logic                 int_req
);

   logic [DATAWIDTH-1:0] mem_x [MEMX_DEPTH];
   logic [DATAWIDTH-1:0] mem_y [MEMY_DEPTH];
   logic [DATAWIDTH-1:0] mem_z [MEMZ_DEPTH];

   logic [4:0]           ptr_x, ptr_y;
   logic [5:0]           ptr_z;
   logic [4:0]           size_x, size_y;
   logic                 done, done_nxt;
   logic [7:0]           mask;
   logic                 start_q;

   logic [4:0]           x_addr, y_addr;
   logic                 z_we;
   logic [5:0]           z_addr;
   logic [DATAWIDTH-1:0] z_data;
   logic                 done_set;
   logic [1:0]           core_state;

   logic                 busy, go;
   logic                 x_wr, y_wr, x_step, y_step, z_step, cfg_wr, stat_wr;
   logic [DATAWIDTH-1:0] status, rd_mux;

   // Access decode; X/Y/DCONFIG writes are locked out while the core runs.
   always_comb begin
      busy    = (core_state != ST_IDLE);
      go      = start && !start_q && !busy;
      x_wr    = write && !busy && (conf_dbus == ADDR_MDATAINX);
      y_wr    = write && !busy && (conf_dbus == ADDR_MDATAINY);
      x_step  = x_wr || (read && (conf_dbus == ADDR_MDATAINX));
      y_step  = y_wr || (read && (conf_dbus == ADDR_MDATAINY));
      z_step  = read && (conf_dbus == ADDR_MDATAOUT);
      cfg_wr  = write && !busy && (conf_dbus == ADDR_DCONFIG);
      stat_wr = write && (conf_dbus == ADDR_STATUS);
   end

   // DONE flag: host write-1-to-clear, start clears, completion sets and wins.
   always_comb begin
      done_nxt = done;
      if (stat_wr && data_in[STAT_DONE]) done_nxt = 1'b0;
      if (go)                            done_nxt = 1'b0;
      if (done_set)                      done_nxt = 1'b1;
   end

   // STATUS view and read-data mux.
   always_comb begin
      status                       = '0;
      status[STAT_DONE]            = done;
      status[STAT_BUSY]            = busy;
      status[STAT_MASK_LO +: 8]    = mask;
      rd_mux = '0;
      case (conf_dbus)
         ADDR_MDATAINX: rd_mux = mem_x[ptr_x];
         ADDR_ADATAINX: rd_mux = {27'd0, ptr_x};
         ADDR_MDATAINY: rd_mux = mem_y[ptr_y];
         ADDR_ADATAINY: rd_mux = {27'd0, ptr_y};
         ADDR_MDATAOUT: rd_mux = mem_z[ptr_z];
         ADDR_ADATAOUT: rd_mux = {26'd0, ptr_z};
         ADDR_DCONFIG:  rd_mux = {22'd0, size_y, size_x};
         ADDR_ACONFIG:  rd_mux = '0;
         ADDR_STATUS:   rd_mux = status;
         ADDR_IP_ID:    rd_mux = IP_ID;
         default:       rd_mux = '0;
      endcase
   end

   // Control registers, pointers and registered read data.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         ptr_x    <= '0;
         ptr_y    <= '0;
         ptr_z    <= '0;
         size_x   <= '0;
         size_y   <= '0;
         done     <= 1'b0;
         mask     <= '0;
         start_q  <= 1'b0;
         data_out <= '0;
      end else if (en_s) begin
         start_q <= start;
         done    <= done_nxt;
         if (stat_wr) mask <= data_in[STAT_MASK_LO +: 8];
         if (cfg_wr) begin
            size_x <= data_in[4:0];
            size_y <= data_in[9:5];
         end
         if (write && (conf_dbus == ADDR_ADATAINX)) ptr_x <= data_in[4:0];
         else if (x_step)                           ptr_x <= ptr_x + 5'd1;
         if (write && (conf_dbus == ADDR_ADATAINY)) ptr_y <= data_in[4:0];
         else if (y_step)                           ptr_y <= ptr_y + 5'd1;
         if (write && (conf_dbus == ADDR_ADATAOUT)) ptr_z <= data_in[5:0];
         else if (z_step)                           ptr_z <= ptr_z + 6'd1;
         if (read) data_out <= rd_mux;
      end
   end

   // Memory write ports (contents are not reset).
   always_ff @(posedge clk) begin
      if (en_s) begin
         if (x_wr) mem_x[ptr_x]  <= data_in;
         if (y_wr) mem_y[ptr_y]  <= data_in;
         if (z_we) mem_z[z_addr] <= z_data;
      end
   end

   assign int_req = ~|({7'd0, done} & mask);

   id1000500a_conv_core u_core (
      .clk       (clk),
      .rst_a     (rst_a),
      .en_s      (en_s),
      .go        (go),
      .size_x    (size_x),
      .size_y    (size_y),
      .x_data    (mem_x[x_addr]),
      .y_data    (mem_y[y_addr]),
      .x_addr    (x_addr),
      .y_addr    (y_addr),
      .z_we      (z_we),
      .z_addr    (z_addr),
      .z_data    (z_data),
      .done_set  (done_set),
      .dbg_state (core_state)
   );

endmodule

// File: tb/tb_id1000500a_conv.sv
// Bench for id1000500a_conv: AIP bus driver tasks, a C-style convolution model that
// pushes expected Z words into exp_q, and bus reads that pop and compare them.
module tb_id1000500a_conv;

   logic        clk = 1'b0;
   logic        rst_a = 1'b0;
   logic        en_s = 1'b1;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  conf_dbus = '0;
   logic        int_req;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] xv [32];
   logic [31:0] yv [32];
   logic [31:0] zm [64];
   logic [31:0] rd;
   bit          ok;

   id1000500a_conv dut (
      .clk       (clk),
      .rst_a     (rst_a),
      .en_s      (en_s),
      .data_in   (data_in),
      .data_out  (data_out),
      .write     (write),
      .read      (read),
      .start     (start),
      .conf_dbus (conf_dbus),
      .int_req   (int_req)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_a = 1'b0;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
      @(negedge clk);
      conf_dbus = a;
      data_in   = v;
      write     = 1'b1;
      @(negedge clk);
      write     = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      conf_dbus = a;
      read      = 1'b1;
      @(posedge clk);
      #1;
      d    = data_out;
      read = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit done_ok);
      logic [31:0] s;
      done_ok = 1'b0;
      for (int i = 0; i < budget && !done_ok; i++) begin
         bus_read(5'd30, s);
         if (s[0]) done_ok = 1'b1;
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
`ifdef CONV_SAT_EN
      longint s;
      s = longint'(signed'(a)) + longint'(signed'(b));
      if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
      return s[31:0];
`else
      return a + b;
`endif
   endfunction

   task automatic model_push(input int sx, input int sy);
      logic [31:0] acc, p;
      for (int n = 0; n <= sx + sy - 2; n++) begin
         acc = '0;
         for (int k = 0; k < sx; k++) begin
            if (n - k >= 0 && n - k < sy) begin
               p   = xv[k] * yv[n-k];
               acc = model_add(acc, p);
            end
         end
         zm[n] = acc;
         exp_q.push_back(acc);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic prep(input int sx, input int sy);
      bus_write(5'd1, 32'd0);
      for (int i = 0; i < sx; i++) bus_write(5'd0, xv[i]);
      bus_write(5'd3, 32'd0);
      for (int i = 0; i < sy; i++) bus_write(5'd2, yv[i]);
      bus_write(5'd7, 32'd0);
      bus_write(5'd6, {22'd0, 5'(sy), 5'(sx)});
      model_push(sx, sy);
   endtask

   task automatic drain_z(input string tag, input int count, input logic [5:0] first);
      logic [31:0] d;
      bus_write(5'd5, {26'd0, first});
      for (int i = 0; i < count; i++) begin
         bus_read(5'd4, d);
         if (exp_q.size() == 0) check({tag, "_q_empty"}, d, 32'hxxxx_xxxx);
         else check(tag, d, exp_q.pop_front());
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      apply_reset();

      // Reset state
      bus_read(5'd31, rd); check("ip_id", rd, 32'h1000_500A);
      bus_read(5'd30, rd); check("status_rst", rd, 32'h0);
      check("int_req_rst", {31'd0, int_req}, 32'd1);

      // Basic convolution [1,2,3]*[1,1]
      xv[0] = 1; xv[1] = 2; xv[2] = 3; yv[0] = 1; yv[1] = 1;
      prep(3, 2);
      bus_read(5'd6, rd); check("dconfig_rd", rd, 32'h43);
      pulse_start();
      wait_done(50, ok); check("done_basic", {31'd0, ok}, 32'd1);
      bus_read(5'd30, rd); check("status_done", rd, 32'h1);
      check("int_unmasked", {31'd0, int_req}, 32'd1);
      drain_z("z_basic", 4, 6'd0);
      bus_read(5'd5, rd); check("zptr_inc", rd, 32'd4);
      en_s = 1'b0;
      bus_write(5'd5, 32'd9);
      en_s = 1'b1;
      bus_read(5'd5, rd); check("en_s_hold", rd, 32'd4);
      bus_write(5'd1, 32'd1);
      bus_read(5'd0, rd); check("x_readback", rd, 32'd2);

      // Interrupt mask flow
      bus_write(5'd30, 32'h0001_0001);
      check("int_cleared", {31'd0, int_req}, 32'd1);
      prep(3, 2);
      pulse_start();
      wait_done(50, ok); check("done_mask", {31'd0, ok}, 32'd1);
      check("int_asserted", {31'd0, int_req}, 32'd0);
      bus_read(5'd30, rd); check("status_mask_done", rd, 32'h0001_0001);
      drain_z("z_mask", 4, 6'd0);
      bus_write(5'd30, 32'h0001_0001);
      bus_read(5'd30, rd); check("status_w1c", rd, 32'h0001_0000);
      check("int_released", {31'd0, int_req}, 32'd1);

      // Random 10 x 5, full 32-bit values to exercise wrap-around
      for (int i = 0; i < 10; i++) xv[i] = $urandom;
      for (int i = 0; i < 5; i++)  yv[i] = $urandom;
      prep(10, 5);
      pulse_start();
      wait_done(100, ok); check("done_rand", {31'd0, ok}, 32'd1);
      drain_z("z_rand", 14, 6'd0);
      exp_q.push_back(zm[2]);
      exp_q.push_back(zm[3]);
      drain_z("z_offset", 2, 6'd2);

      // Modulo product
      xv[0] = 32'hFFFF_FFFF; yv[0] = 32'd2;
      prep(1, 1);
      pulse_start();
      wait_done(20, ok); check("done_wrap", {31'd0, ok}, 32'd1);
      bus_write(5'd5, 32'd0);
      bus_read(5'd4, rd); check("z_wrap", rd, 32'hFFFF_FFFE);

      // Empty run (sizeY = 0): quick DONE, no Z writes
      bus_write(5'd6, 32'h3);
      pulse_start();
      wait_done(4, ok); check("done_empty", {31'd0, ok}, 32'd1);
      bus_write(5'd5, 32'd0);
      bus_read(5'd4, rd); check("z_untouched", rd, 32'hFFFF_FFFE);

      // Reset in the middle of a calculation
      bus_write(5'd30, 32'h00FF_0000);
      for (int i = 0; i < 10; i++) xv[i] = $urandom_range(0, 1000);
      for (int i = 0; i < 5; i++)  yv[i] = $urandom_range(0, 1000);
      prep(10, 5);
      exp_q.delete();
      pulse_start();
      repeat (10) @(negedge clk);
      apply_reset();
      bus_read(5'd30, rd); check("status_after_rst", rd, 32'h0);
      check("int_after_rst", {31'd0, int_req}, 32'd1);
      bus_read(5'd5, rd); check("zptr_after_rst", rd, 32'd0);

      // Fresh run; X/DCONFIG writes and a second start while busy are ignored
      for (int i = 0; i < 10; i++) xv[i] = $urandom;
      for (int i = 0; i < 5; i++)  yv[i] = $urandom;
      prep(10, 5);
      pulse_start();
      bus_write(5'd1, 32'd0);
      bus_write(5'd0, 32'hDEAD_BEEF);
      bus_write(5'd6, 32'h21);
      pulse_start();
      wait_done(100, ok); check("done_rerun", {31'd0, ok}, 32'd1);
      bus_read(5'd6, rd); check("dconfig_locked", rd, 32'hAA);
      drain_z("z_rerun", 14, 6'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
